// File: rtl/pc_fetch_ctl.sv
// Program-counter register and fetch sequencer with run/halt control,
// misaligned-target trap and saturating performance counters.
module pc_fetch_ctl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic [31:0]      pc_new,
  input  logic             branched,
  input  logic             is_jump,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  // state  | meaning
  // S_RUN  | fetching; commits pc_new each enabled, unstalled cycle
  // S_HALT | frozen after halt_req or misaligned target; resume leaves unless trapped
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0] state;
  logic       target_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pc_4       = pc + 32'd4;
  assign halted     = (state == S_HALT);
  assign target_bad = (pc_new[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      misalign   <= 1'b0;
      cnt_cycle  <= '0;
      cnt_branch <= '0;
      cnt_jump   <= '0;
    end else if (en) begin
      if (state == S_RUN) begin
        cnt_cycle <= sat_inc(cnt_cycle);
        if (halt_req) begin
          state <= S_HALT;
        end else if (!stall) begin
          if (target_bad) begin
            // trap holds pc at the offending instruction for inspection
            misalign <= 1'b1;
            state    <= S_HALT;
          end else begin
            pc <= pc_new;
            if (branched) cnt_branch <= sat_inc(cnt_branch);
            if (is_jump)  cnt_jump   <= sat_inc(cnt_jump);
          end
        end
      end else begin
        if (resume && !misalign) begin
          state <= S_RUN;
          pc    <= pc_4;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// Self-checking bench for pc_fetch_ctl: directed scenarios plus randomized
// traffic against a behavioural model; a 4-bit-counter copy checks saturation.
module tb_pc_fetch_ctl;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, en, stall, halt_req, resume, branched, is_jump;
  logic [31:0] pc_new;

  logic [31:0] pc, pc_4;
  logic        halted, misalign;
  logic [31:0] cnt_cycle, cnt_branch, cnt_jump;

  logic [31:0] s_pc, s_pc_4;
  logic        s_halted, s_misalign;
  logic [3:0]  s_cycle, s_branch, s_jump;

  int checks   = 0;
  int failures = 0;

  // behavioural model
  logic [31:0]     m_pc;
  bit              m_halt, m_mis;
  longint unsigned m_cyc, m_br, m_jp;

  pc_fetch_ctl #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .halt_req(halt_req),
    .resume(resume), .pc_new(pc_new), .branched(branched), .is_jump(is_jump),
    .pc(pc), .pc_4(pc_4), .halted(halted), .misalign(misalign),
    .cnt_cycle(cnt_cycle), .cnt_branch(cnt_branch), .cnt_jump(cnt_jump)
  );

  pc_fetch_ctl #(.RESET_PC(RPC), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .halt_req(halt_req),
    .resume(resume), .pc_new(pc_new), .branched(branched), .is_jump(is_jump),
    .pc(s_pc), .pc_4(s_pc_4), .halted(s_halted), .misalign(s_misalign),
    .cnt_cycle(s_cycle), .cnt_branch(s_branch), .cnt_jump(s_jump)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sat4(input longint unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  // One enabled instruction slot, stated as the architectural rules
  task automatic model_step();
    if (rst) begin
      m_pc = RPC; m_halt = 0; m_mis = 0; m_cyc = 0; m_br = 0; m_jp = 0;
    end else if (en) begin
      if (!m_halt) begin
        m_cyc++;
        if (halt_req) m_halt = 1;
        else if (stall) begin end
        else if (pc_new % 4 != 0) begin m_mis = 1; m_halt = 1; end
        else begin
          m_pc = pc_new;
          if (branched) m_br++;
          if (is_jump)  m_jp++;
        end
      end else if (resume && !m_mis) begin
        m_halt = 0;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; en = 1; stall = 0; halt_req = 0; resume = 0;
    branched = 0; is_jump = 0; pc_new = 32'h0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0;
    checks++; if (pc !== 32'h0040_0000) begin failures++; $display("FAIL reset_pc got=%h exp=00400000", pc); end
    checks++; if (pc_4 !== 32'h0040_0004) begin failures++; $display("FAIL reset_pc_4 got=%h exp=00400004", pc_4); end
    checks++; if (halted !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", halted, misalign); end
    checks++; if ({cnt_cycle, cnt_branch, cnt_jump} !== 96'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", cnt_cycle, cnt_branch, cnt_jump); end
    checks++; if ({s_cycle, s_branch, s_jump} !== 12'h0) begin failures++; $display("FAIL reset_cnt_small got=%h exp=000", {s_cycle, s_branch, s_jump}); end
  endtask

  task automatic test_seq_branch();
    logic [31:0] exp;
    idle();
    for (int i = 0; i < 3; i++) begin
      exp = pc_4; pc_new = pc_4; tick();
      checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, pc, exp); end
    end
    pc_new = 32'h0040_0100; branched = 1; tick(); branched = 0;
    checks++; if (pc !== 32'h0040_0100) begin failures++; $display("FAIL branch_pc got=%h exp=00400100", pc); end
    pc_new = 32'h0040_0200; is_jump = 1; tick(); is_jump = 0;
    checks++; if (pc !== 32'h0040_0200) begin failures++; $display("FAIL jump_pc got=%h exp=00400200", pc); end
    checks++; if (cnt_cycle !== 32'd5 || cnt_branch !== 32'd1 || cnt_jump !== 32'd1)
      begin failures++; $display("FAIL seq_cnt got=%0d/%0d/%0d exp=5/1/1", cnt_cycle, cnt_branch, cnt_jump); end
  endtask

  task automatic test_stall_en();
    idle(); stall = 1; branched = 1; pc_new = 32'h1234_5678;
    tick(); tick();
    en = 0; stall = 0; branched = 0;
    tick(); tick(); tick();
    idle();
    checks++; if (pc !== 32'h0040_0200) begin failures++; $display("FAIL stall_pc got=%h exp=00400200", pc); end
    checks++; if (cnt_cycle !== 32'd7 || cnt_branch !== 32'd1)
      begin failures++; $display("FAIL stall_cnt got=%0d/%0d exp=7/1", cnt_cycle, cnt_branch); end
  endtask

  task automatic test_halt_resume();
    idle(); rst = 1; tick(); rst = 0;
    pc_new = 32'h0040_0010; tick();
    halt_req = 1; tick(); halt_req = 0;
    checks++; if (halted !== 1'b1 || pc !== 32'h0040_0010) begin failures++; $display("FAIL halt_enter got=%b/%h exp=1/00400010", halted, pc); end
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; halt_req = ~i[0]; pc_new = $urandom & 32'hFFFF_FFFC; branched = 1; is_jump = 1;
      tick();
      checks++; if (halted !== 1'b1 || pc !== 32'h0040_0010 || cnt_cycle !== 32'd2 || cnt_branch !== 32'd0)
        begin failures++; $display("FAIL halt_hold step=%0d got=%b/%h/%0d/%0d exp=1/00400010/2/0", i, halted, pc, cnt_cycle, cnt_branch); end
    end
    idle(); resume = 1; tick(); resume = 0;
    checks++; if (halted !== 1'b0 || pc !== 32'h0040_0014 || cnt_cycle !== 32'd2)
      begin failures++; $display("FAIL resume got=%b/%h/%0d exp=0/00400014/2", halted, pc, cnt_cycle); end
  endtask

  task automatic test_misalign();
    idle(); pc_new = 32'h0040_0022; branched = 1; tick(); branched = 0;
    checks++; if (misalign !== 1'b1 || halted !== 1'b1 || pc !== 32'h0040_0014 || cnt_branch !== 32'd0)
      begin failures++; $display("FAIL misalign_trap got=%b/%b/%h/%0d exp=1/1/00400014/0", misalign, halted, pc, cnt_branch); end
    idle(); resume = 1; tick(); resume = 0;
    checks++; if (halted !== 1'b1 || pc !== 32'h0040_0014) begin failures++; $display("FAIL misalign_resume got=%b/%h exp=1/00400014", halted, pc); end
    rst = 1; tick(); rst = 0;
    checks++; if (misalign !== 1'b0 || halted !== 1'b0 || pc !== RPC) begin failures++; $display("FAIL misalign_clear got=%b/%b/%h exp=0/0/%h", misalign, halted, pc, RPC); end
  endtask

  task automatic test_wrap_saturate();
    idle(); rst = 1; tick(); rst = 0;
    pc_new = 32'hFFFF_FFFC; tick();
    checks++; if (pc_4 !== 32'h0000_0000 || s_pc_4 !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc_4 got=%h exp=00000000", pc_4); end
    for (int i = 0; i < 20; i++) begin
      pc_new = pc_4; branched = 1; tick();
    end
    idle();
    checks++; if (s_branch !== 4'hF || s_cycle !== 4'hF || s_jump !== 4'h0)
      begin failures++; $display("FAIL saturate got=%h/%h/%h exp=F/F/0", s_branch, s_cycle, s_jump); end
    checks++; if (cnt_branch !== 32'd20 || cnt_cycle !== 32'd21)
      begin failures++; $display("FAIL wide_cnt got=%0d/%0d exp=20/21", cnt_branch, cnt_cycle); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      en       = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      branched = $urandom_range(0, 1);
      is_jump  = $urandom_range(0, 1);
      pc_new   = $urandom;
      if ($urandom_range(0, 39) != 0) pc_new[1:0] = 2'b00;
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc i=%0d got=%h exp=%h", i, pc, m_pc); end
      checks++; if (pc_4 !== m_pc + 32'd4) begin failures++; $display("FAIL rand_pc_4 i=%0d got=%h exp=%h", i, pc_4, m_pc + 32'd4); end
      checks++; if (halted !== m_halt || misalign !== m_mis) begin failures++; $display("FAIL rand_flags i=%0d got=%b%b exp=%b%b", i, halted, misalign, m_halt, m_mis); end
      checks++; if (cnt_cycle !== m_cyc[31:0]) begin failures++; $display("FAIL rand_cycle i=%0d got=%0d exp=%0d", i, cnt_cycle, m_cyc); end
      checks++; if (cnt_branch !== m_br[31:0] || cnt_jump !== m_jp[31:0]) begin failures++; $display("FAIL rand_bj i=%0d got=%0d/%0d exp=%0d/%0d", i, cnt_branch, cnt_jump, m_br, m_jp); end
      checks++; if (s_cycle !== sat4(m_cyc) || s_branch !== sat4(m_br) || s_jump !== sat4(m_jp))
        begin failures++; $display("FAIL rand_small i=%0d got=%h/%h/%h exp=%h/%h/%h", i, s_cycle, s_branch, s_jump, sat4(m_cyc), sat4(m_br), sat4(m_jp)); end
      checks++; if (s_pc !== m_pc || s_halted !== m_halt || s_misalign !== m_mis)
        begin failures++; $display("FAIL rand_small_pc i=%0d got=%h exp=%h", i, s_pc, m_pc); end
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_seq_branch();
    test_stall_en();
    test_halt_resume();
    test_misalign();
    test_wrap_saturate();
    idle(); rst = 1; tick(); rst = 0;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
